// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch-unit bus: instruction-memory port, redirect and
//               decode-side valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int PC_WIDTH    = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 3
);
    logic [PC_WIDTH-1:0]    fu_out_imem_addr;
    logic [DATA_WIDTH-1:0]  fu_in_imem_data;
    logic                   fu_in_redirect;
    logic [PC_WIDTH-1:0]    fu_in_target;
    logic                   fu_in_ready;
    logic                   fu_out_valid;
    logic [DATA_WIDTH-1:0]  fu_out_instr;
    logic [PC_WIDTH-1:0]    fu_out_pc;
    logic [COUNT_WIDTH-1:0] fu_out_count;

    // master is the fetch unit itself; slave is memory plus pipeline side
    modport master (
        output fu_out_imem_addr, fu_out_valid, fu_out_instr, fu_out_pc, fu_out_count,
        input  fu_in_imem_data, fu_in_redirect, fu_in_target, fu_in_ready
    );

    modport slave (
        input  fu_out_imem_addr, fu_out_valid, fu_out_instr, fu_out_pc, fu_out_count,
        output fu_in_imem_data, fu_in_redirect, fu_in_target, fu_in_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end: PC, synchronous imem access and
//               an instruction FIFO presented to decode via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                   PC_WIDTH   = 10,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic          fu_in_clk,
    input  logic          fu_in_rst,
    fetch_unit_if.master  fu
);
    localparam int                  c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]    c_DEPTH    = (c_CNT_W+1)'(FIFO_DEPTH);
    localparam logic [PC_WIDTH-1:0] c_PC_ONE   = 1;
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = 1;

    logic [PC_WIDTH-1:0]   r_fetch_pc;
    logic                  r_inflight_valid;
    logic [PC_WIDTH-1:0]   r_inflight_pc;
    logic [DATA_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   r_pc_mem    [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    logic [c_CNT_W:0]      w_occupancy;
    logic                  w_has_space;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop;

    // Reserving a slot for the in-flight word guarantees its push never drops
    assign w_occupancy = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight_valid};
    assign w_has_space = (w_occupancy < c_DEPTH);
    assign w_valid     = (r_count != '0);
    assign w_push      = r_inflight_valid;
    assign w_pop       = w_valid && fu.fu_in_ready;

    always_ff @(posedge fu_in_clk) begin
        if (fu_in_rst) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
        end else if (fu.fu_in_redirect) begin
            r_fetch_pc       <= fu.fu_in_target;
            r_inflight_valid <= 1'b0;
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
        end else begin
            if (w_has_space) begin
                r_fetch_pc       <= r_fetch_pc + c_PC_ONE;
                r_inflight_valid <= 1'b1;
                r_inflight_pc    <= r_fetch_pc;
            end else begin
                r_inflight_valid <= 1'b0;
            end
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only observed when counted valid
    always_ff @(posedge fu_in_clk) begin
        if (!fu_in_rst && !fu.fu_in_redirect && w_push) begin
            r_instr_mem[r_tail] <= fu.fu_in_imem_data;
            r_pc_mem[r_tail]    <= r_inflight_pc;
        end
    end

    assign fu.fu_out_imem_addr = r_fetch_pc;
    assign fu.fu_out_valid     = w_valid;
    assign fu.fu_out_instr     = w_valid ? r_instr_mem[r_head] : '0;
    assign fu.fu_out_pc        = w_valid ? r_pc_mem[r_head] : '0;
    assign fu.fu_out_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    localparam int PCW   = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    fetch_unit_if #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .COUNT_WIDTH(3)) bus  ();
    fetch_unit_if #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .COUNT_WIDTH(3)) bus2 ();

    fetch_unit #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(10'd0)) dut (
        .fu_in_clk (clk),
        .fu_in_rst (rst),
        .fu        (bus)
    );

    fetch_unit #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(10'd1022)) dut2 (
        .fu_in_clk (clk),
        .fu_in_rst (rst),
        .fu        (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [PCW-1:0] a);
        return 32'h0000_0100 + 32'(a);
    endfunction

    // Synchronous instruction memory: word for the address sampled at edge N is valid in cycle N+1
    always @(posedge clk) begin
        bus.fu_in_imem_data  <= mem_word(bus.fu_out_imem_addr);
        bus2.fu_in_imem_data <= mem_word(bus2.fu_out_imem_addr);
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: buffered words as a queue of PCs, plus fetch/in-flight PCs
    logic [PCW-1:0] m_q[$];
    logic [PCW-1:0] m_fpc;
    logic [PCW-1:0] m_ipc;
    logic           m_infl;
    logic           m_live = 1'b0;
    logic           m_issue;
    logic [PCW-1:0] delivered[$];

    always @(negedge clk) begin
        if (m_live) begin
            check("mdl_valid", 32'(bus.fu_out_valid), 32'(m_q.size() != 0));
            check("mdl_count", 32'(bus.fu_out_count), 32'(m_q.size()));
            check("mdl_addr",  32'(bus.fu_out_imem_addr), 32'(m_fpc));
            check("mdl_instr", 32'(bus.fu_out_instr), (m_q.size() != 0) ? mem_word(m_q[0]) : 32'h0);
            check("mdl_pc",    32'(bus.fu_out_pc), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        end
        if (!rst && !bus.fu_in_redirect && bus.fu_in_ready && bus.fu_out_valid)
            delivered.push_back(bus.fu_out_pc);
        // Advance the model to the state after the coming rising edge
        if (rst) begin
            m_q.delete();
            m_fpc  = 10'd0;
            m_infl = 1'b0;
            m_ipc  = 10'd0;
            m_live = 1'b1;
        end else if (bus.fu_in_redirect) begin
            m_q.delete();
            m_fpc  = bus.fu_in_target;
            m_infl = 1'b0;
        end else if (m_live) begin
            m_issue = (m_q.size() + int'(m_infl)) < DEPTH;
            if (m_q.size() != 0 && bus.fu_in_ready) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_ipc);
            if (m_issue) begin
                m_ipc  = m_fpc;
                m_infl = 1'b1;
                m_fpc  = m_fpc + 10'd1;
            end else begin
                m_infl = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.fu_in_ready     = 1'b0;
        bus.fu_in_redirect  = 1'b0;
        bus.fu_in_target    = '0;
        bus2.fu_in_ready    = 1'b1;
        bus2.fu_in_redirect = 1'b0;
        bus2.fu_in_target   = '0;
        tick();
        tick();
        // Cold start with ready=1: reset values, then first word in cycle 3
        rst = 1'b0;
        bus.fu_in_ready = 1'b1;
        check("rst_valid", 32'(bus.fu_out_valid), 32'h0);
        check("rst_instr", 32'(bus.fu_out_instr), 32'h0);
        check("rst_pc",    32'(bus.fu_out_pc), 32'h0);
        check("rst_count", 32'(bus.fu_out_count), 32'h0);
        check("rst_addr",  32'(bus.fu_out_imem_addr), 32'h0);
        check("rst_addr2", 32'(bus2.fu_out_imem_addr), 32'd1022);
        tick();
        check("c2_valid", 32'(bus.fu_out_valid), 32'h0);
        tick();
        check("c3_valid", 32'(bus.fu_out_valid), 32'h1);
        check("c3_instr", 32'(bus.fu_out_instr), 32'h100);
        check("c3_pc",    32'(bus.fu_out_pc), 32'h0);
        check("wrap_pc0", 32'(bus2.fu_out_pc), 32'd1022);
        tick();
        check("c4_pc",    32'(bus.fu_out_pc), 32'h1);
        check("wrap_pc1", 32'(bus2.fu_out_pc), 32'd1023);
        tick();
        check("c5_pc",    32'(bus.fu_out_pc), 32'h2);
        check("wrap_pc2", 32'(bus2.fu_out_pc), 32'd0);
        check("wrap_ins2", 32'(bus2.fu_out_instr), 32'h100);
        tick();
        check("wrap_pc3", 32'(bus2.fu_out_pc), 32'd1);
        check("wrap_vld3", 32'(bus2.fu_out_valid), 32'h1);

        // Backpressure: ten cycles without ready, then drain
        rst = 1'b1;
        bus.fu_in_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("bp_count", 32'(bus.fu_out_count), 32'd4);
        check("bp_addr",  32'(bus.fu_out_imem_addr), 32'd4);
        check("bp_pc",    32'(bus.fu_out_pc), 32'd0);
        delivered.delete();
        bus.fu_in_ready = 1'b1;
        repeat (14) tick();
        check("bp_len", 32'(delivered.size() >= 10), 32'h1);
        for (int i = 0; i < 10; i++)
            check("bp_order", 32'(delivered[i]), 32'(i));

        // Redirect with three buffered words
        rst = 1'b1;
        bus.fu_in_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rd_pre_cnt", 32'(bus.fu_out_count), 32'd3);
        bus.fu_in_redirect = 1'b1;
        bus.fu_in_target   = 10'h200;
        tick();
        bus.fu_in_redirect = 1'b0;
        bus.fu_in_ready    = 1'b1;
        delivered.delete();
        check("rd_valid", 32'(bus.fu_out_valid), 32'h0);
        check("rd_count", 32'(bus.fu_out_count), 32'h0);
        check("rd_addr",  32'(bus.fu_out_imem_addr), 32'h200);
        tick();
        tick();
        check("rd_t_valid", 32'(bus.fu_out_valid), 32'h1);
        check("rd_t_instr", 32'(bus.fu_out_instr), 32'h300);
        check("rd_t_pc",    32'(bus.fu_out_pc), 32'h200);
        repeat (3) tick();
        check("rd_first", 32'(delivered[0]), 32'h200);

        // Redirect coinciding with a consumed head: head must not be delivered
        delivered.delete();
        bus.fu_in_redirect = 1'b1;
        bus.fu_in_target   = 10'h050;
        tick();
        bus.fu_in_redirect = 1'b0;
        check("rr_valid", 32'(bus.fu_out_valid), 32'h0);
        tick();
        tick();
        check("rr_pc",    32'(bus.fu_out_pc), 32'h050);
        check("rr_instr", 32'(bus.fu_out_instr), 32'h150);
        tick();
        check("rr_first", 32'(delivered[0]), 32'h050);

        // Mid-stream reset with two buffered words
        bus.fu_in_ready = 1'b0;
        tick();
        check("mr_pre_cnt", 32'(bus.fu_out_count), 32'd2);
        rst = 1'b1;
        bus.fu_in_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(bus.fu_out_valid), 32'h0);
        check("mr_count", 32'(bus.fu_out_count), 32'h0);
        check("mr_addr",  32'(bus.fu_out_imem_addr), 32'h0);
        tick();
        tick();
        check("mr_c3_vld", 32'(bus.fu_out_valid), 32'h1);
        check("mr_c3_pc",  32'(bus.fu_out_pc), 32'h0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the pipelined MIPS core. It owns the program counter, drives the synchronous instruction memory (`mem_inst`), and buffers returned words in a small FIFO. It presents them to the decode stage with a valid/ready handshake, so the PC register, the IR_1 load and the branch/jump flush logic leave the pipeline body. Taken branches and jumps resolved in execute arrive as a one-cycle redirect that flushes everything fetched past the control instruction.

## Interface
- PC_WIDTH, 10, instruction-memory address width; PC is a word index.
- DATA_WIDTH, 32, instruction width.
- FIFO_DEPTH, 4, instruction-buffer entries; power of two, ≥2.
- RESET_PC, 0, fetch address after reset.
- fu_in_clk  in  1  core clock (board-divided clock).
- fu_in_rst  in  1  reset; synchronous, active-high.
- fu_out_imem_addr  out  PC_WIDTH  address to `mem_inst`.
- fu_in_imem_data  in  DATA_WIDTH  `mem_inst` q; word for the address sampled at edge N is valid during cycle N+1.
- fu_in_redirect  in  1  taken branch/jump, one-cycle pulse.
- fu_in_target  in  PC_WIDTH  redirect target; sampled only with fu_in_redirect.
- fu_in_ready  in  1  decode accepts the head instruction this cycle.
- fu_out_valid  out  1  head instruction available.
- fu_out_instr  out  DATA_WIDTH  head instruction; 0 (nop) when fu_out_valid=0.
- fu_out_pc  out  PC_WIDTH  word address of the head instruction; 0 when fu_out_valid=0.
- fu_out_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- State: fetch_pc, inflight_valid, inflight_pc, FIFO with head/tail pointers and count. No other FSM.
- fu_out_imem_addr = fetch_pc, combinational, always driven.
- Issue condition: count + inflight_valid < FIFO_DEPTH, and no redirect. If issued, fetch_pc += 1 (wraps 2^PC_WIDTH−1 → 0), inflight_valid←1, inflight_pc←fetch_pc. Otherwise inflight_valid←0 and fetch_pc holds.
- Return: if inflight_valid, {fu_in_imem_data, inflight_pc} is pushed at the edge. Space is guaranteed by the issue condition, so a push is never dropped.
- Pop: fu_out_valid && fu_in_ready. Head advances. fu_in_ready with an empty FIFO is ignored.
- Push and pop in the same cycle are both performed; count is unchanged.
- Redirect has priority over all of the above. At the edge: FIFO emptied (count←0), inflight_valid←0, fetch_pc←fu_in_target, no push, no pop. A simultaneous fu_in_ready is not a consumption.
- Reset has priority over redirect. At the edge: fetch_pc←RESET_PC, count←0, pointers←0, inflight_valid←0. A reset in mid-stream discards buffered and in-flight words.
- Arithmetic: PC is modulo 2^PC_WIDTH. No byte offset, no alignment check.

## Timing
- Reset values: fu_out_valid=0, fu_out_instr=0, fu_out_pc=0, fu_out_count=0, fu_out_imem_addr=RESET_PC.
- Fetch latency: the address is issued in cycle C, the data is pushed at the end of C+1, and fu_out_valid=1 in C+2. There is no empty-FIFO bypass.
- First instruction: fu_in_rst released after edge E0; RESET_PC is issued in cycle 1; fu_out_valid=1 in cycle 3.
- Redirect latency: redirect sampled at edge E. fu_out_valid=0 from cycle E+1. The target word is valid in cycle E+3.
- Throughput: with fu_in_ready held at 1, one instruction per cycle after the first, with no bubbles.
- Backpressure: with fu_in_ready=0, count saturates at FIFO_DEPTH and issue stops. When ready returns, there are no lost or duplicated instructions.
- Outputs are registered FIFO reads plus a valid mask. There is no combinational path from fu_in_ready or fu_in_redirect to any output.

## Test plan
- Reset, then fu_in_ready=1, with mem[i]=0x0000_0100+i → first fu_out_valid in cycle 3 after reset release with instr 0x100, pc 0. Afterwards pc 1,2,3… one per cycle with no gaps.
- Hold fu_in_ready=0 for 10 cycles → fu_out_count reaches 4 and fu_out_imem_addr stops advancing (holds 4). Release ready → pcs 0..9 delivered in order, each exactly once.
- FIFO holding 3 entries; pulse fu_in_redirect with target 0x200 → fu_out_valid=0 next cycle, count=0. Three cycles after the pulse, instr=mem[0x200] and pc=0x200. No pre-redirect word ever appears afterwards.
- RESET_PC=1022, ready=1 → pcs 1022, 1023, 0, 1 on consecutive valid cycles.
- Redirect and fu_in_ready=1 in the same cycle with a valid head → head discarded and not re-presented; next valid is the target.
- Assert fu_in_rst for one cycle during streaming with count=2 → next cycle valid=0 and count=0; stream restarts at RESET_PC with a 3-cycle latency.
